// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master Wishbone classic round-robin arbiter, grant held for the whole cycle.
// Define WB_ARB_TIMEOUT_EN to force an error on a slave stalled for TIMEOUT_CYCLES strobes.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic                              s_we_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GRANTED, RECOVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANTED} state_t;
`endif
  state_t state, state_nxt;
  logic [IW-1:0] last, win, idx;
  logic act, to;
  always_comb begin
    win = last;
    idx = '0;
    // scan from farthest to nearest so the nearest requester after last wins
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_MASTERS);
      if (m_cyc_i[idx]) win = idx;
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && |m_cyc_i) state_nxt = GRANTED;
    else if (state != IDLE && !m_cyc_i[last]) state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
    if (to) state_nxt = RECOVER;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_o <= '0;
      last    <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && |m_cyc_i) begin
        last    <= win;
        grant_o <= NUM_MASTERS'(1) << win;
      end else if (state_nxt == IDLE) grant_o <= '0;
    end
  end
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic term;
  assign term = s_ack_i | s_err_i | s_rty_i;
  assign to = act && s_stb_o && !term && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || !act || term) cnt <= '0;
    else if (s_stb_o) cnt <= cnt + 1'b1;
  end
`else
  assign to = 1'b0;
`endif
  assign act       = state == GRANTED;
  assign timeout_o = to;
  assign s_cyc_o   = act & m_cyc_i[last];
  assign s_stb_o   = act & m_stb_i[last];
  assign s_we_o    = act & m_we_i[last];
  assign s_adr_o   = act ? m_adr_i[last*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o   = act ? m_dat_i[last*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign s_sel_o   = act ? m_sel_i[last*SEL_WIDTH +: SEL_WIDTH] : '0;
  assign m_ack_o   = act && s_ack_i ? grant_o : '0;
  assign m_err_o   = act && (s_err_i || to) ? grant_o : '0;
  assign m_rty_o   = act && s_rty_i ? grant_o : '0;
  assign m_dat_o   = s_dat_i;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed plus random checks of wb_rr_arbiter against a cycle-level ownership model.
module tb_wb_rr_arbiter;
  localparam int N = 4, DW = 128, AW = 32, SW = 16, T = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N-1:0] m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
  int total = 0, bad = 0;
  int owner = -1, last = N - 1, cnt = 0;
  bit rec = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .grant_o(grant_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    m_adr_i = '0; m_dat_i = '0; m_we_i = '0; m_sel_i = '0; m_stb_i = '0; m_cyc_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  // one clock: compare outputs with the model, then advance the model on the edge
  task automatic step();
    bit act, to, term;
    int o;
    logic [N-1:0] oh;
    #1;
    act  = owner >= 0 && !rec;
    o    = owner < 0 ? 0 : owner;
    oh   = owner >= 0 ? N'(1) << owner : '0;
    term = s_ack_i | s_err_i | s_rty_i;
    to   = TO_EN && act && m_stb_i[o] && !term && cnt + 1 == T;
    check("grant", grant_o, oh);
    check("s_cyc", s_cyc_o, act && m_cyc_i[o]);
    check("s_stb", s_stb_o, act && m_stb_i[o]);
    check("s_we", s_we_o, act && m_we_i[o]);
    check("s_adr", s_adr_o, act ? m_adr_i[o*AW +: AW] : '0);
    check("s_dat", s_dat_o, act ? m_dat_i[o*DW +: DW] : '0);
    check("s_sel", s_sel_o, act ? m_sel_i[o*SW +: SW] : '0);
    check("m_ack", m_ack_o, act && s_ack_i ? oh : '0);
    check("m_err", m_err_o, act && (s_err_i || to) ? oh : '0);
    check("m_rty", m_rty_o, act && s_rty_i ? oh : '0);
    check("timeout", timeout_o, to);
    check("m_dat", m_dat_o, s_dat_i);
    @(posedge clk);
    if (rst) begin
      owner = -1; last = N - 1; rec = 0; cnt = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (m_cyc_i[c]) begin
          owner = c; last = c; cnt = 0;
          break;
        end
      end
    end else if (rec) begin
      if (!m_cyc_i[owner]) begin owner = -1; rec = 0; end
    end else begin
      cnt = term ? 0 : cnt + int'(m_stb_i[owner]);
      if (to) rec = 1;
      else if (!m_cyc_i[owner]) owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    clr();
    @(posedge clk); @(negedge clk);
    step();
    check("rst_grant", grant_o, '0);
    check("rst_cyc", s_cyc_o, 0);
    rst = 0;
    // single requester, master 2
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100; m_adr_i[2*AW +: AW] = 32'h1000;
    step();
    check("t1_grant", grant_o, 4'b0100);
    s_ack_i = 1;
    #1 check("t1_adr", s_adr_o, 32'h1000);
    check("t1_ack", m_ack_o, 4'b0100);
    step();
    m_cyc_i = '0; s_ack_i = 0;
    step();
    check("t1_idle", grant_o, '0);
    // all masters requesting: strict rotation with one idle cycle between owners
    do_reset();
    m_cyc_i = '1; m_stb_i = '1; s_ack_i = 1;
    for (int e = 0; e < 5; e++) begin
      step();
      check("rot_grant", grant_o, N'(1) << (e % N));
      step();
      m_cyc_i[e % N] = 0;
      step();
      check("rot_gap", grant_o, '0);
      m_cyc_i[e % N] = 1;
    end
    // no pre-emption during a 3-beat burst
    clr(); do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    step();
    m_cyc_i[0] = 1; m_stb_i[0] = 1; s_ack_i = 1;
    for (int b = 0; b < 3; b++) begin
      check("burst_grant", grant_o, 4'b0010);
      step();
    end
    m_cyc_i[1] = 0; s_ack_i = 0;
    step();
    check("burst_rel", grant_o, '0);
    step();
    check("burst_next", grant_o, 4'b0001);
    // master 3 write on lane 1
    clr(); do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000; m_we_i = 4'b1000;
    m_sel_i[3*SW +: SW] = 16'h00F0;
    m_dat_i[3*DW +: DW] = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000;
    step();
    s_ack_i = 1;
    #1 check("wr_we", s_we_o, 1);
    check("wr_sel", s_sel_o, 16'h00F0);
    check("wr_dat", s_dat_o, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000);
    check("wr_ack", m_ack_o, 4'b1000);
    step();
    // reset while master 2 is stalled; a late ack must not be forwarded
    clr(); do_reset();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    step(); step();
    rst = 1; m_cyc_i = '0;
    step();
    rst = 0;
    check("rst_mid_cyc", s_cyc_o, 0);
    check("rst_mid_grant", grant_o, '0);
    step();
    s_ack_i = 1;
    #1 check("rst_late_ack", m_ack_o, '0);
    step();
    // stalled slave
    clr(); do_reset();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= T; i++) begin
      #1 check("to_pulse", timeout_o, i == T);
      check("to_err", m_err_o, i == T ? 4'b0001 : 4'b0000);
      step();
    end
    check("to_rec_cyc", s_cyc_o, 0);
    check("to_rec_grant", grant_o, 4'b0001);
    step();
    m_cyc_i = '0;
    step();
    check("to_idle", grant_o, '0);
`else
    for (int i = 0; i < 100; i++) begin
      #1 check("noto_pulse", timeout_o, 0);
      check("noto_err", m_err_o, '0);
      step();
    end
    check("noto_grant", grant_o, 4'b0001);
`endif
    // random traffic
    clr(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      for (int i = 0; i < N; i++) begin
        if (!m_cyc_i[i]) m_cyc_i[i] = $urandom_range(0, 2) == 0;
        else if (i == owner) m_cyc_i[i] = $urandom_range(0, 3) != 0;
        else m_cyc_i[i] = $urandom_range(0, 19) != 0;
        m_stb_i[i] = $urandom_range(0, 3) != 0;
        m_we_i[i] = 1'($urandom);
        m_adr_i[i*AW +: AW] = $urandom;
        m_dat_i[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        m_sel_i[i*SW +: SW] = 16'($urandom);
      end
      s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      s_ack_i = $urandom_range(0, 2) == 0;
      s_err_i = $urandom_range(0, 15) == 0;
      s_rty_i = $urandom_range(0, 15) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
